// File: rtl/noise_generator_mc.sv
// noise_generator_mc: CHANNELS independent 32-bit Galois LFSR noise sources,
// served round-robin on one valid/ready stream, with runtime reseed, a
// post-seed warm-up phase and 2-bit level scaling.
// Build option: define NOISE_GAUSS_EN to average four chained LFSR steps per
// sample (approximately Gaussian). The default build is uniform, single-step.
//
// state     | meaning
// ST_SEED   | one cycle: every channel loads its seed derived from seed_base
// ST_WARMUP | every channel steps each cycle, WARMUP cycles, output idle
// ST_RUN    | samples generated round-robin into the output register

module noise_generator_mc #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WARMUP    = 16,
  parameter logic [31:0] BASE_SEED = 32'h0000ABCD,
  localparam int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       noise_level,
  input  logic             reseed,
  input  logic [31:0]      seed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_chan,
  output logic             busy
);

  localparam logic [31:0] TAPS   = 32'hB4BCD35C;
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  typedef enum logic [1:0] {ST_SEED, ST_WARMUP, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [31:0]       seed_base_q, seed_base_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]     out_chan_q, out_chan_d;
  logic [31:0]       lfsr_q [CHANNELS];
  logic [31:0]       lfsr_d [CHANNELS];

  logic [31:0]       sel_state;
  logic [31:0]       sel_next;
  logic [WIDTH-1:0]  sample_raw;
  logic              load;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so a zero seed becomes 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned c);
    logic [31:0] seed;
    seed = base ^ (32'(c) * GOLDEN);
    return (seed == 32'h0) ? 32'h1 : seed;
  endfunction

  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] raw, input logic [1:0] lvl);
    logic signed [WIDTH-1:0] s;
    logic [WIDTH-1:0]        r;
    s = raw;
    case (lvl)
      2'b01:   r = s >>> 4;
      2'b10:   r = s >>> 3;
      2'b11:   r = s >>> 2;
      default: r = '0;
    endcase
    return r;
  endfunction

  // pick the state of the channel currently being served
  always_comb begin
    sel_state = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ptr_q == CW'(c)) sel_state = lfsr_q[c];
    end
  end

`ifdef NOISE_GAUSS_EN
  logic [31:0]          s1, s2, s3;
  logic signed [WIDTH+1:0] gsum;

  function automatic logic [WIDTH+1:0] ext(input logic [31:0] s);
    return {{2{s[31]}}, s[31:32-WIDTH]};
  endfunction

  // four chained steps, summed at WIDTH+2 bits and divided by four
  always_comb begin
    s1         = lfsr_step(sel_state);
    s2         = lfsr_step(s1);
    s3         = lfsr_step(s2);
    gsum       = ext(sel_state) + ext(s1) + ext(s2) + ext(s3);
    sample_raw = gsum[WIDTH+1:2];
    sel_next   = lfsr_step(s3);
  end
`else
  assign sample_raw = sel_state[31:32-WIDTH];
  assign sel_next   = lfsr_step(sel_state);
`endif

  assign load = (state_q == ST_RUN) && !reseed && enable && (!out_valid_q || out_ready);

  // next-state, channel update and output register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    seed_base_d = seed_base_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    for (int unsigned c = 0; c < CHANNELS; c++) lfsr_d[c] = lfsr_q[c];

    case (state_q)
      ST_SEED: begin
        for (int unsigned c = 0; c < CHANNELS; c++) lfsr_d[c] = chan_seed(seed_base_q, c);
        out_valid_d = 1'b0;
        ptr_d       = '0;
        if (WARMUP == 0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WARMUP;
          cnt_d   = 8'(WARMUP - 1);
        end
      end
      ST_WARMUP: begin
        for (int unsigned c = 0; c < CHANNELS; c++) lfsr_d[c] = lfsr_step(lfsr_q[c]);
        if (cnt_q == 8'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_RUN: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = scale(sample_raw, noise_level);
          out_chan_d  = ptr_q;
          ptr_d       = (ptr_q == CW'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ptr_q == CW'(c)) lfsr_d[c] = sel_next;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_SEED;
    endcase

    // a reseed discards any pending sample and restarts seeding
    if (reseed) begin
      state_d     = ST_SEED;
      seed_base_d = seed_in;
      out_valid_d = 1'b0;
      ptr_d       = '0;
    end
  end

  // FSM state, timers, channel LFSRs and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SEED;
      cnt_q       <= 8'd0;
      ptr_q       <= '0;
      seed_base_q <= BASE_SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) lfsr_q[c] <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      seed_base_q <= seed_base_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      for (int unsigned c = 0; c < CHANNELS; c++) lfsr_q[c] <= lfsr_d[c];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_noise_generator_mc.sv
// Bench for noise_generator_mc: a single-channel, no-warm-up instance checked
// against hand-computed constants, and a four-channel instance with WARMUP=3
// checked against a small reference model of the LFSR stream.

`timescale 1ns/1ps

module tb_noise_generator_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  noise_level;
  logic        reseed;
  logic [31:0] seed_in;
  logic        out_ready;

  logic        a_valid, a_busy;
  logic [15:0] a_data;
  logic [0:0]  a_chan;
  logic        b_valid, b_busy;
  logic [15:0] b_data;
  logic [1:0]  b_chan;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mst [4];
  int          mptr;
  logic [15:0] first_ch0;

  always #5 clk = ~clk;

  noise_generator_mc #(.WIDTH(16), .CHANNELS(1), .WARMUP(0), .BASE_SEED(32'h1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .noise_level(noise_level),
    .reseed(reseed), .seed_in(seed_in), .out_valid(a_valid), .out_ready(out_ready),
    .out_data(a_data), .out_chan(a_chan), .busy(a_busy)
  );

  noise_generator_mc #(.WIDTH(16), .CHANNELS(4), .WARMUP(3), .BASE_SEED(32'h1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .noise_level(noise_level),
    .reseed(reseed), .seed_in(seed_in), .out_valid(b_valid), .out_ready(out_ready),
    .out_data(b_data), .out_chan(b_chan), .busy(b_busy)
  );

  function automatic logic [31:0] m_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'hB4BCD35C : 32'h0);
  endfunction

  function automatic logic [31:0] m_chan_seed(input logic [31:0] s, input int c);
    logic [31:0] r;
    r = s ^ (32'(c) * 32'h9E3779B9);
    if (r == 32'h0) r = 32'h1;
    return r;
  endfunction

  function automatic logic [15:0] m_sample(input logic [31:0] s, input logic [1:0] lvl);
    logic signed [15:0] raw;
    logic [15:0]        r;
    raw = s[31:16];
    case (lvl)
      2'd1:    r = raw >>> 4;
      2'd2:    r = raw >>> 3;
      2'd3:    r = raw >>> 2;
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  // seed all four model channels and apply three warm-up steps
  task automatic m_seed(input logic [31:0] s);
    for (int c = 0; c < 4; c++) begin
      mst[c] = m_chan_seed(s, c);
      for (int k = 0; k < 3; k++) mst[c] = m_step(mst[c]);
    end
    mptr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; a transfer on dut_b at this edge is scored against the model
  task automatic tick();
    if (b_valid && out_ready) begin
      chk("sb_data", {16'h0, b_data}, {16'h0, m_sample(mst[mptr], noise_level)});
      chk("sb_chan", {30'h0, b_chan}, mptr);
      mst[mptr] = m_step(mst[mptr]);
      mptr = (mptr + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    enable    = 1'b0;
    out_ready = 1'b1;
    while (b_valid && n < 8) begin
      tick();
      n++;
    end
    chk("drain_done", {31'h0, b_valid}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; noise_level = 2'd3;
    reseed = 1'b0; seed_in = 32'h0; out_ready = 1'b1;
    m_seed(32'h1);
    first_ch0 = m_sample(mst[0], 2'd3);
    repeat (3) begin @(posedge clk); #1; end

    chk("rst_a_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_a_data",  {16'h0, a_data},  32'h0);
    chk("rst_a_chan",  {31'h0, a_chan},  32'h0);
    chk("rst_a_busy",  {31'h0, a_busy},  32'h1);
    chk("rst_b_valid", {31'h0, b_valid}, 32'h0);
    chk("rst_b_chan",  {30'h0, b_chan},  32'h0);
    chk("rst_b_busy",  {31'h0, b_busy},  32'h1);

    reset = 1'b0;
    tick();
    chk("a_valid_c1", {31'h0, a_valid}, 32'h0);
    chk("a_busy_c1",  {31'h0, a_busy},  32'h0);
    chk("b_busy_c1",  {31'h0, b_busy},  32'h1);
    tick();
    chk("a_valid_c2", {31'h0, a_valid}, 32'h1);
    chk("a_data_c2",  {16'h0, a_data},  32'h0000);
    chk("a_chan_c2",  {31'h0, a_chan},  32'h0);
    chk("b_busy_c2",  {31'h0, b_busy},  32'h1);
    tick();
    chk("a_data_c3",  {16'h0, a_data},  32'hED2F);
    chk("a_chan_c3",  {31'h0, a_chan},  32'h0);
    chk("b_busy_c3",  {31'h0, b_busy},  32'h1);
    tick();
    chk("b_busy_c4",  {31'h0, b_busy},  32'h0);
    chk("b_valid_c4", {31'h0, b_valid}, 32'h0);
    tick();
    chk("b_valid_c5", {31'h0, b_valid}, 32'h1);
    chk("b_first",    {16'h0, b_data},  {16'h0, first_ch0});

    // round-robin channel order at full throughput
    for (int i = 0; i < 6; i++) begin
      chk("rr_chan",  {30'h0, b_chan},  i % 4);
      chk("rr_valid", {31'h0, b_valid}, 32'h1);
      chk("rr_busy",  {31'h0, b_busy},  32'h0);
      tick();
    end

    // back-pressure holds the sample stable
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'h0, b_valid}, 32'h1);
      chk("stall_data",  {16'h0, b_data},  {16'h0, m_sample(mst[mptr], noise_level)});
      chk("stall_chan",  {30'h0, b_chan},  mptr);
    end
    out_ready = 1'b1;
    tick();
    chk("release_chan",  {30'h0, b_chan},  mptr);
    chk("release_valid", {31'h0, b_valid}, 32'h1);

    // level 00 still yields valid (zero) samples
    drain();
    noise_level = 2'd0;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("lvl0_valid", {31'h0, b_valid}, 32'h1);
      chk("lvl0_data",  {16'h0, b_data},  32'h0);
      tick();
    end
    drain();
    noise_level = 2'd3;
    enable = 1'b1;
    tick();
    chk("lvl3_valid", {31'h0, b_valid}, 32'h1);

    // enable dropped with a pending sample
    out_ready = 1'b0;
    tick();
    chk("en_pending", {31'h0, b_valid}, 32'h1);
    enable = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("en_drop", {31'h0, b_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_idle", {31'h0, b_valid}, 32'h0);
    end
    enable = 1'b1;
    tick();
    chk("en_resume", {31'h0, b_valid}, 32'h1);
    chk("en_resume_chan", {30'h0, b_chan}, mptr);
    repeat (4) tick();

    // reseed with zero mid-stream: channel 0 falls back to seed 1
    seed_in = 32'h0;
    reseed = 1'b1;
    tick();
    m_seed(32'h0);
    reseed = 1'b0;
    chk("rs_valid", {31'h0, b_valid}, 32'h0);
    chk("rs_busy",  {31'h0, b_busy},  32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_busy_w",  {31'h0, b_busy},  32'h1);
      chk("rs_valid_w", {31'h0, b_valid}, 32'h0);
    end
    tick();
    chk("rs_busy_run", {31'h0, b_busy},  32'h0);
    chk("rs_valid_run", {31'h0, b_valid}, 32'h0);
    tick();
    chk("rs_valid_1st", {31'h0, b_valid}, 32'h1);
    chk("rs_chan_1st",  {30'h0, b_chan},  32'h0);
    chk("rs_ch0_match", {16'h0, b_data},  {16'h0, first_ch0});
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_generator_mc.md
# noise_generator_mc

Multi-channel, parametrised pseudo-random noise source. It replaces the single 16-bit LFSR noise block and provides:
- `CHANNELS` independent 32-bit Galois LFSRs, served round-robin on one valid/ready output stream;
- runtime reseeding and a post-seed warm-up phase;
- level scaling as before: 2-bit level, right shift by 4 / 3 / 2.

It feeds the signal-impairment path, where noise is added to DSP samples per channel.

## Interface
Parameters:
- `WIDTH`, 16, output sample width in bits (8..32).
- `CHANNELS`, 4, number of independent LFSR channels (1..16).
- `WARMUP`, 16, LFSR steps discarded after reset or reseed (0..255).
- `BASE_SEED`, 32'h0000ABCD, seed used at reset.

Ports (all synchronous to `clk`):
- `clk`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  allows new samples to be generated.
- `noise_level`  in  2  scaling: 00 = zero, 01 = `>>>4`, 10 = `>>>3`, 11 = `>>>2`.
- `reseed`  in  1  one-cycle request to load `seed_in`.
- `seed_in`  in  32  new base seed.
- `out_valid`  out  1  `out_data` / `out_chan` hold a sample.
- `out_ready`  in  1  downstream accepts the sample.
- `out_data`  out  WIDTH  signed noise sample.
- `out_chan`  out  max(1, clog2(CHANNELS))  channel index of the sample.
- `busy`  out  1  high in SEED and WARMUP states.

## Operation
- LFSR step: `next = (s >> 1) ^ (s[0] ? 32'hB4BCD35C : 0)`.
- Channel seed: `seed_c = S ^ (c * 32'h9E3779B9)`, taken modulo 2^32, where `S` is `BASE_SEED` or `seed_in`.
  - If `seed_c == 0`, the channel loads 32'h1 instead.
- Raw sample: `s[31:32-WIDTH]` of the channel's current state, read as signed.
  - Scaled sample = `raw >>> shift`, with shift taken from `noise_level` at generation time.
  - Level 00 produces 0 but still produces a valid sample.
- A channel's LFSR advances only when it generates a sample. Exception: the WARMUP state, where all channels step every cycle.
- State machine:
  - SEED: for one cycle, all channels load `seed_c`. Next state is WARMUP, or RUN if `WARMUP == 0`.
  - WARMUP: counts `WARMUP` cycles, then goes to RUN.
  - RUN: normal operation. `reseed` in any state goes to SEED next cycle.
- `reset` and `reseed` both use SEED:
  - `reset` enters SEED with `S = BASE_SEED`.
  - `reseed` enters SEED with `S = seed_in`, sampled in the cycle `reseed` is high.
- RUN, output register behaviour:
  - The output register loads when it is empty, or when it is full and `out_ready` is high, provided `enable` is high.
  - It loads the sample of channel `ptr`, then `ptr` increments and wraps from `CHANNELS-1` to 0.
- Handshake:
  - A transfer occurs when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, `out_data` and `out_chan` are held stable.
- `enable` low:
  - No new loads and no LFSR advance.
  - A pending sample stays valid until it is accepted, then `out_valid` drops.
- Reseed or reset mid-operation:
  - `out_valid` drops the next cycle and any pending sample is discarded.
  - `ptr` returns to 0.
- `reseed` held for several cycles restarts SEED each cycle. `reset` has priority over `reseed`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `busy`=1, `ptr`=0, state=SEED.
- From the cycle after `reset` (or `reseed`) deasserts, `busy` stays high for 1 + `WARMUP` cycles.
  - First `out_valid` occurs one cycle after RUN is entered, if `enable` is high.
- Throughput: one sample per cycle while `out_ready` and `enable` are high. No bubbles.
- Latency: `enable` rising to `out_valid` (output register empty) = 1 cycle.

## Configuration
- `NOISE_GAUSS_EN` defined:
  - Each generated sample chains four LFSR steps combinationally: s0 = current state, s1, s2, s3.
  - Sample = `(raw(s0)+raw(s1)+raw(s2)+raw(s3)) >>> 2`, summed at WIDTH+2 bits, before level scaling.
  - The channel state advances to step(s3).
  - WARMUP still advances one step per cycle.
- `NOISE_GAUSS_EN` undefined: uniform single-step behaviour as described above, and no adder logic is present.

## Test plan
- Reset with `BASE_SEED`=1, `WARMUP`=0, `CHANNELS`=1, level 11, `enable`=1, `out_ready`=1:
  - `out_data` = 16'h0000, then 16'hED2F.
  - `out_chan` = 0 throughout.
  - `out_valid` first high 2 cycles after `reset` falls.
- `CHANNELS`=4, `out_ready`=1: `out_chan` sequence is 0,1,2,3,0,1; one sample per cycle; `busy`=0 throughout RUN.
- Hold `out_ready`=0 for 5 cycles with `out_valid` high:
  - `out_data` and `out_chan` are unchanged.
  - On release, the next `out_chan` is the previous value +1.
- Level 00 with `enable`=1: every accepted `out_data` = 0 and `out_valid` still toggles normally.
- `reseed` with `seed_in`=32'h0 mid-stream:
  - `out_valid` drops the next cycle.
  - `busy` is high for 1+`WARMUP` cycles.
  - Channel 0 output stream then matches that of a seed-1 reset.
- `enable` dropped with a sample pending: the sample is delivered once, then `out_valid`=0 until `enable` returns. The LFSR does not advance, so the stream resumes where it stopped.
